// File: rtl/multiport_register_file.sv
// multiport_register_file: parametrised 2R/2W architectural register bank with
// write-to-read bypass, optional hardwired-zero entry, valid flags and clear sweep.
`default_nettype none

// ============================================================================
//  Module   : multiport_register_file
//  Brief    : Two asynchronous read ports, two write ports (port 1 wins on
//             address collision), per-entry written-valid flags and a
//             sequential clear-sweep engine that blocks writes while busy.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module multiport_register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid1,
    output logic              rvalid2,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              wen1,
    input  logic              clr,
    output logic              busy
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ptr_last = '1;
    localparam logic            c_zero_on  = (ZERO_REG != 0);
    localparam logic            c_byp_on   = (BYPASS != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;

    logic                w_wen0;
    logic                w_wen1;

    // Effective write enables: dropped during a sweep and for the hardwired zero entry.
    assign w_wen0 = wen0 && !busy_q && !(c_zero_on && (waddr0 == '0));
    assign w_wen1 = wen1 && !busy_q && !(c_zero_on && (waddr1 == '0));

    // ------------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == c_ptr_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage array and valid flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]   <= '0;
                valid_q[i] <= c_zero_on && (i == 0);
            end
        end else if (state_q == SWEEP) begin
            mem_q[ptr_q]   <= '0;
            valid_q[ptr_q] <= c_zero_on && (ptr_q == '0);
        end else begin
            // Port 1 is applied last so it wins an address collision.
            if (w_wen0) begin
                mem_q[waddr0]   <= wdata0;
                valid_q[waddr0] <= 1'b1;
            end
            if (w_wen1) begin
                mem_q[waddr1]   <= wdata1;
                valid_q[waddr1] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: stored value, optional same-cycle forwarding, zero entry
    // ------------------------------------------------------------------------
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] d;
        logic              v;
        d = mem_q[ra];
        v = valid_q[ra];
        if (c_byp_on) begin
            if (w_wen1 && (waddr1 == ra)) begin
                d = wdata1;
                v = 1'b1;
            end else if (w_wen0 && (waddr0 == ra)) begin
                d = wdata0;
                v = 1'b1;
            end
        end
        if (c_zero_on && (ra == '0)) begin
            d = '0;
            v = 1'b1;
        end
        return {v, d};
    endfunction

    always_comb begin
        {rvalid1, rdata1} = read_port(raddr1);
        {rvalid2, rdata2} = read_port(raddr2);
    end

    assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: directed self-checking bench for the register file.
`default_nettype none

// ============================================================================
//  Module   : tb_multiport_register_file
//  Brief    : Directed vectors with hand-computed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multiport_register_file;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] raddr1, raddr2;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              rvalid1, rvalid2;
    logic [ADDR_W-1:0] waddr0, waddr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              wen0, wen1;
    logic              clr;
    logic              busy;

    int n_checks;
    int n_fail;
    int cnt;

    multiport_register_file #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1),
        .BYPASS  (1)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .rvalid1(rvalid1),
        .rvalid2(rvalid2),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .wen0   (wen0),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .wen1   (wen1),
        .clr    (clr),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and leave 1 time unit of margin after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; clr = 1'b0;
        raddr1 = '0; raddr2 = '0;
        waddr0 = '0; wdata0 = '0; wen0 = 1'b0;
        waddr1 = '0; wdata1 = '0; wen1 = 1'b0;

        // 1. Reset state
        tick();
        rst = 1'b0; raddr1 = 4'd4; raddr2 = 4'd5;
        #1;
        check("rst_rdata1", 32'(rdata1), 32'h0);
        check("rst_rdata2", 32'(rdata2), 32'h0);
        check("rst_rvalid1", 32'(rvalid1), 32'h0);
        check("rst_rvalid2", 32'(rvalid2), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // 2. Writes on each port in consecutive cycles
        wen0 = 1'b1; waddr0 = 4'd4; wdata0 = 16'h2021;
        tick();
        wen0 = 1'b0;
        wen1 = 1'b1; waddr1 = 4'd5; wdata1 = 16'h5159;
        tick();
        wen1 = 1'b0;
        #1;
        check("wr_rdata1", 32'(rdata1), 32'h2021);
        check("wr_rdata2", 32'(rdata2), 32'h5159);
        check("wr_rvalid1", 32'(rvalid1), 32'h1);
        check("wr_rvalid2", 32'(rvalid2), 32'h1);

        // 3. Same-address collision: port 1 wins, bypass before the edge
        wen0 = 1'b1; waddr0 = 4'd7; wdata0 = 16'hAAAA;
        wen1 = 1'b1; waddr1 = 4'd7; wdata1 = 16'h5555;
        raddr1 = 4'd7; raddr2 = 4'd4;
        #1;
        check("byp_rdata1", 32'(rdata1), 32'h5555);
        check("byp_rvalid1", 32'(rvalid1), 32'h1);
        check("byp_other_port", 32'(rdata2), 32'h2021);
        tick();
        wen0 = 1'b0; wen1 = 1'b0;
        #1;
        check("coll_stored", 32'(rdata1), 32'h5555);

        // Port-0-only bypass to a fresh entry
        wen0 = 1'b1; waddr0 = 4'd9; wdata0 = 16'h0909; raddr2 = 4'd9;
        #1;
        check("byp0_rdata2", 32'(rdata2), 32'h0909);
        check("byp0_rvalid2", 32'(rvalid2), 32'h1);
        tick();
        wen0 = 1'b0;

        // 4. Hardwired zero entry
        wen0 = 1'b1; waddr0 = 4'd0; wdata0 = 16'hFFFF; raddr1 = 4'd0;
        #1;
        check("zero_byp_rdata", 32'(rdata1), 32'h0);
        check("zero_byp_rvalid", 32'(rvalid1), 32'h1);
        tick();
        wen0 = 1'b0;
        #1;
        check("zero_rdata", 32'(rdata1), 32'h0);
        check("zero_rvalid", 32'(rvalid1), 32'h1);

        // 5. Fill entries 1..15, two per cycle where possible
        for (int i = 1; i < 16; i += 2) begin
            wen0 = 1'b1; waddr0 = 4'(i); wdata0 = 16'h1000 + 16'(i);
            wen1 = (i + 1 < 16); waddr1 = 4'(i + 1); wdata1 = 16'h1000 + 16'(i + 1);
            tick();
        end
        wen0 = 1'b0; wen1 = 1'b0;
        raddr1 = 4'd15; raddr2 = 4'd8;
        #1;
        check("fill_e15", 32'(rdata1), 32'h100F);
        check("fill_e8", 32'(rdata2), 32'h1008);

        // clr together with a write: the write still commits
        clr = 1'b1; wen0 = 1'b1; waddr0 = 4'd2; wdata0 = 16'hBEEF; raddr2 = 4'd2;
        tick();
        clr = 1'b0;
        // Writes held active for the whole sweep must be dropped, no bypass
        waddr0 = 4'd15; wdata0 = 16'h7777;
        #1;
        check("clr_wr_commit", 32'(rdata2), 32'hBEEF);
        check("sweep_busy", 32'(busy), 32'h1);
        check("sweep_no_byp", 32'(rdata1), 32'h100F);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        check("sweep_len", 32'(cnt), 32'd16);
        wen0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr1 = 4'(i);
            #1;
            check($sformatf("post_clr_data%0d", i), 32'(rdata1), 32'h0);
            check($sformatf("post_clr_valid%0d", i), 32'(rvalid1), (i == 0) ? 32'h1 : 32'h0);
        end

        // 6. Reset aborts a sweep
        wen1 = 1'b1; waddr1 = 4'd10; wdata1 = 16'hABCD;
        tick();
        wen1 = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; raddr1 = 4'd10; raddr2 = 4'd3;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_e10_data", 32'(rdata1), 32'h0);
        check("abort_e10_valid", 32'(rvalid1), 32'h0);
        wen0 = 1'b1; waddr0 = 4'd3; wdata0 = 16'h1234;
        tick();
        wen0 = 1'b0;
        #1;
        check("abort_idle_busy", 32'(busy), 32'h0);
        check("post_abort_wr", 32'(rdata2), 32'h1234);
        check("post_abort_valid", 32'(rvalid2), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
